icache_direct: RTL

Direct-mapped, one-word-per-line instruction cache between the instruction fetch stage and the memory controller. Serves fetch requests with one-cycle hit latency. On a miss, issues a single word fetch to the memory controller, fills the line, and returns the word. Squashes in-flight responses on pipeline flush without ever abandoning a fetch the controller may already have accepted.

---
 rtl/icache_direct.sv | 136 +++++++++++++
 1 files changed

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped one-word-per-line instruction cache
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  input  logic        flush,
  output logic        mc_fet_ena,
  output logic [31:0] mc_addr,
  input  logic        mc_valid,
  input  logic [31:0] mc_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_W = 30 - IDX_W;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

  state_t             state_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [31:0]        data_q [LINES];
  logic [IDX_W-1:0]   miss_idx_q;
  logic [TAG_W-1:0]   miss_tag_q;
  logic               if_valid_q;
  logic [31:0]        if_instr_q;
  logic               mc_fet_ena_q;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               accept_hit;
  logic               accept_miss;
  logic               fill_en;
  logic               unused_addr_bits;

  assign req_idx          = if_addr[IDX_W+1:2];
  assign req_tag          = if_addr[31:IDX_W+2];
  assign unused_addr_bits = ^if_addr[1:0];
  assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // flush wins over a same-cycle request, so neither outcome is accepted
  assign accept_hit       = rdy && (state_q == IDLE) && if_req && !flush && hit;
  assign accept_miss      = rdy && (state_q == IDLE) && if_req && !flush && !hit;
  assign fill_en          = rdy && (state_q != IDLE) && mc_valid;

  assign if_valid   = if_valid_q;
  assign if_instr   = if_instr_q;
  assign mc_fet_ena = mc_fet_ena_q;
  assign mc_addr    = {miss_tag_q, miss_idx_q, 2'b00};

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[miss_idx_q]  <= miss_tag_q;
      data_q[miss_idx_q] <= mc_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      mc_fet_ena_q <= 1'b0;
    end else if (rdy) begin
      if_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_hit) begin
            if_valid_q <= 1'b1;
            if_instr_q <= data_q[req_idx];
          end else if (accept_miss) begin
            mc_fet_ena_q <= 1'b1;
            miss_idx_q   <= req_idx;
            miss_tag_q   <= req_tag;
            state_q      <= MISS;
          end
        end
        MISS: begin
          if (mc_valid) begin
            valid_q[miss_idx_q] <= 1'b1;
            mc_fet_ena_q        <= 1'b0;
            state_q             <= IDLE;
            if (!flush) begin
              if_valid_q <= 1'b1;
              if_instr_q <= mc_data;
            end
          end else if (flush) begin
            // the controller cannot cancel, so keep the request up and drain it
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (mc_valid) begin
            valid_q[miss_idx_q] <= 1'b1;
            mc_fet_ena_q        <= 1'b0;
            state_q             <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept_hit && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (accept_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
